// File: rtl/pin_sequencer.sv
// pin_sequencer: lock-pick mini-game sequencer.
// The pick is steered by keycodes. The selected pin is "set" by holding the
// pick inside its Y window for HOLD_FRAMES frames. Pins must be set in the
// order given by bind_order. Too many out-of-order attempts fail the round.
module pin_sequencer #(
   parameter int         NUM_PINS    = 5,
   parameter logic [9:0] PIN_Y_BASE  = 10'd200,
   parameter logic [9:0] PIN_Y_STEP  = 10'd16,
   parameter logic [9:0] WINDOW      = 10'd4,
   parameter logic [7:0] HOLD_FRAMES = 8'd30,
   parameter logic [1:0] MAX_STRIKES = 2'd3
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic        start,
   input  logic [7:0]  keycode,
   input  logic [14:0] bind_order,
   input  logic [9:0]  pickY,
   output logic [2:0]  dir,
   output logic [2:0]  active_pin,
   output logic [4:0]  pin_set,
   output logic [1:0]  strikes,
   output logic [2:0]  state,
   output logic        unlocked,
   output logic        failed
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PICKING  = 3'd1;
   localparam logic [2:0] S_CHECK    = 3'd2;
   localparam logic [2:0] S_UNLOCKED = 3'd3;
   localparam logic [2:0] S_FAILED   = 3'd4;

   localparam logic [7:0] KEY_UP    = 8'h1A;
   localparam logic [7:0] KEY_DOWN  = 8'h16;
   localparam logic [7:0] KEY_UP2   = 8'h52;
   localparam logic [7:0] KEY_DOWN2 = 8'h51;
   localparam logic [7:0] KEY_DEC   = 8'h04;
   localparam logic [7:0] KEY_INC   = 8'h07;

   localparam logic [2:0] DIR_STOP  = 3'b000;
   localparam logic [2:0] DIR_UP1   = 3'b001;
   localparam logic [2:0] DIR_DN1   = 3'b010;
   localparam logic [2:0] DIR_DN2   = 3'b011;
   localparam logic [2:0] DIR_UP2   = 3'b100;

   localparam logic [2:0] LAST_PIN  = 3'(NUM_PINS - 1);
   localparam logic [2:0] ALL_PINS  = 3'(NUM_PINS);

   logic [2:0]  state_q,      state_d;
   logic [2:0]  dir_q,        dir_d;
   logic [2:0]  active_pin_q, active_pin_d;
   logic [4:0]  pin_set_q,    pin_set_d;
   logic [1:0]  strikes_q,    strikes_d;
   logic [2:0]  next_idx_q,   next_idx_d;
   logic [7:0]  hold_cnt_q,   hold_cnt_d;
   logic [14:0] bind_q,       bind_d;
   logic [7:0]  key_prev_q,   key_prev_d;

   logic [NUM_PINS-1:0] hit;
   logic [2:0]          slot [NUM_PINS];
   logic [2:0]          key_dir;
   logic                press_dec, press_inc;

   // Per-pin window detector and bind-order slot unpack
   for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
      localparam logic [9:0] TARGET = PIN_Y_BASE - PIN_Y_STEP * 10'(g);
      logic [9:0] diff;

      // Unsigned distance between the pick and this pin's target (never wraps)
      always_comb begin
         diff = (pickY >= TARGET) ? (pickY - TARGET) : (TARGET - pickY);
      end

      assign hit[g]  = (diff <= WINDOW);
      assign slot[g] = bind_q[3*g +: 3];
   end

   // Keycode to pick motion code
   always_comb begin
      case (keycode)
         KEY_UP:    key_dir = DIR_UP1;
         KEY_DOWN:  key_dir = DIR_DN1;
         KEY_UP2:   key_dir = DIR_UP2;
         KEY_DOWN2: key_dir = DIR_DN2;
         default:   key_dir = DIR_STOP;
      endcase
   end

   // Pin select keys act only on the frame the keycode changes, so holding a key counts once
   always_comb begin
      press_dec = (keycode == KEY_DEC) && (keycode != key_prev_q);
      press_inc = (keycode == KEY_INC) && (keycode != key_prev_q);
   end

   // Next-state logic for the round FSM and its datapath
   always_comb begin
      state_d      = state_q;
      dir_d        = DIR_STOP;
      active_pin_d = active_pin_q;
      pin_set_d    = pin_set_q;
      strikes_d    = strikes_q;
      next_idx_d   = next_idx_q;
      hold_cnt_d   = hold_cnt_q;
      bind_d       = bind_q;
      key_prev_d   = keycode;

      case (state_q)
         S_IDLE: begin
            pin_set_d    = '0;
            strikes_d    = '0;
            next_idx_d   = '0;
            hold_cnt_d   = '0;
            active_pin_d = '0;
            if (start) begin
               state_d = S_PICKING;
               bind_d  = bind_order;
            end
         end

         S_PICKING: begin
            dir_d = key_dir;
            if (press_dec && (active_pin_q != 3'd0))
               active_pin_d = active_pin_q - 3'd1;
            else if (press_inc && (active_pin_q != LAST_PIN))
               active_pin_d = active_pin_q + 3'd1;

            // A pin switch restarts the hold; an already-set pin never accumulates
            if (active_pin_d != active_pin_q) begin
               hold_cnt_d = '0;
            end else if (hit[active_pin_q] && !pin_set_q[active_pin_q]) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
               if (hold_cnt_d == HOLD_FRAMES) begin
                  hold_cnt_d = '0;
                  state_d    = S_CHECK;
                  dir_d      = DIR_STOP;
               end
            end else begin
               hold_cnt_d = '0;
            end
         end

         S_CHECK: begin
            // Out-of-range or duplicate slots simply never match
            if (active_pin_q == slot[next_idx_q]) begin
               pin_set_d  = pin_set_q | (5'b00001 << active_pin_q);
               next_idx_d = next_idx_q + 3'd1;
               state_d    = (next_idx_d == ALL_PINS) ? S_UNLOCKED : S_PICKING;
            end else begin
               pin_set_d  = '0;
               next_idx_d = '0;
               strikes_d  = strikes_q + 2'd1;
               state_d    = (strikes_d == MAX_STRIKES) ? S_FAILED : S_PICKING;
            end
         end

         S_UNLOCKED, S_FAILED: begin
            if (start) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         dir_q        <= DIR_STOP;
         active_pin_q <= '0;
         pin_set_q    <= '0;
         strikes_q    <= '0;
         next_idx_q   <= '0;
         hold_cnt_q   <= '0;
         bind_q       <= '0;
         key_prev_q   <= '0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         active_pin_q <= active_pin_d;
         pin_set_q    <= pin_set_d;
         strikes_q    <= strikes_d;
         next_idx_q   <= next_idx_d;
         hold_cnt_q   <= hold_cnt_d;
         bind_q       <= bind_d;
         key_prev_q   <= key_prev_d;
      end
   end

   assign dir        = dir_q;
   assign active_pin = active_pin_q;
   assign pin_set    = pin_set_q;
   assign strikes    = strikes_q;
   assign state      = state_q;
   assign unlocked   = (state_q == S_UNLOCKED);
   assign failed     = (state_q == S_FAILED);

endmodule

// File: tb/tb_pin_sequencer.sv
// tb_pin_sequencer: directed stimulus with a cycle-tagged scoreboard.
// The driver pushes expected values due after the next edge; the monitor
// pops and compares them on the falling edge.
module tb_pin_sequencer;

   localparam int F_ST = 0, F_DIR = 1, F_PIN = 2, F_SET = 3, F_STRK = 4, F_UNL = 5, F_FAIL = 6;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [7:0]  key;
   logic [14:0] bind_o;
   logic [9:0]  py;
   logic [2:0]  dir, active_pin, state;
   logic [4:0]  pin_set;
   logic [1:0]  strikes;
   logic        unlocked, failed;

   always #5 clk = ~clk;

   pin_sequencer dut (
      .frame_clk (clk),
      .Reset     (rst),
      .start     (start),
      .keycode   (key),
      .bind_order(bind_o),
      .pickY     (py),
      .dir       (dir),
      .active_pin(active_pin),
      .pin_set   (pin_set),
      .strikes   (strikes),
      .state     (state),
      .unlocked  (unlocked),
      .failed    (failed)
   );

   typedef struct {
      string name;
      int    fld;
      int    val;
      int    due;
   } exp_t;

   exp_t sq[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int getf(input int f);
      case (f)
         F_ST:    return int'(state);
         F_DIR:   return int'(dir);
         F_PIN:   return int'(active_pin);
         F_SET:   return int'(pin_set);
         F_STRK:  return int'(strikes);
         F_UNL:   return int'(unlocked);
         default: return int'(failed);
      endcase
   endfunction

   // Monitor: compare every expectation that has come due
   always @(negedge clk) begin
      exp_t e;
      int   act;
      while (sq.size() > 0 && sq[0].due <= cyc) begin
         e   = sq.pop_front();
         act = getf(e.fld);
         total++;
         if (e.due != cyc) begin
            bad++;
            $display("FAIL %s: check slipped, due cycle %0d seen at %0d", e.name, e.due, cyc);
         end else if (act != e.val) begin
            bad++;
            $display("FAIL %s: field %0d got %0d want %0d (cycle %0d)", e.name, e.fld, act, e.val, cyc);
         end
      end
   end

   task automatic expect_v(input string n, input int f, input int v);
      exp_t e;
      e.name = n;
      e.fld  = f;
      e.val  = v;
      e.due  = cyc + 1;
      sq.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [14:0] pack(input int a0, a1, a2, a3, a4);
      return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
   endfunction

   task automatic do_reset(input string n);
      rst = 1'b1; start = 1'b0; key = 8'h00;
      expect_v({n, "_state"}, F_ST, 0);
      expect_v({n, "_dir"},   F_DIR, 0);
      expect_v({n, "_pin"},   F_PIN, 0);
      expect_v({n, "_set"},   F_SET, 0);
      expect_v({n, "_strk"},  F_STRK, 0);
      expect_v({n, "_unl"},   F_UNL, 0);
      expect_v({n, "_fail"},  F_FAIL, 0);
      tick();
      rst = 1'b0;
   endtask

   task automatic do_start(input string n, input logic [14:0] b, input logic [9:0] y);
      start = 1'b1; bind_o = b; py = y; key = 8'h00;
      expect_v(n, F_ST, 1);
      tick();
      start = 1'b0;
   endtask

   task automatic press_inc(input string n, input int p);
      key = 8'h07;
      expect_v(n, F_PIN, p);
      tick();
   endtask

   // 30 in-window frames (steering up meanwhile), then the one CHECK frame
   task automatic do_hold(input string n, input logic [9:0] y, input int st, input int set, input int strk);
      py = y; key = 8'h1A;
      repeat (28) begin expect_v({n, "_hold"}, F_ST, 1); tick(); end
      expect_v({n, "_hold"}, F_ST, 1);
      expect_v({n, "_hdir"}, F_DIR, 1);
      tick();
      expect_v({n, "_chk"},    F_ST, 2);
      expect_v({n, "_chkdir"}, F_DIR, 0);
      tick();
      expect_v({n, "_st"},   F_ST, st);
      expect_v({n, "_set"},  F_SET, set);
      expect_v({n, "_strk"}, F_STRK, strk);
      tick();
   endtask

   logic [7:0] kc_tab  [5] = '{8'h1A, 8'h16, 8'h52, 8'h51, 8'h2C};
   int         dir_tab [5] = '{1, 2, 4, 3, 0};

   initial begin
      rst = 1'b1; start = 1'b0; key = 8'h00; bind_o = '0; py = '0;

      // Reset values, then in-order unlock of all five pins
      do_reset("rst0");
      do_start("a_start", pack(0, 1, 2, 3, 4), 10'd200);
      do_hold("a_p0", 10'd200, 1, 5'b00001, 0);
      press_inc("a_sel1", 1);
      do_hold("a_p1", 10'd184, 1, 5'b00011, 0);
      press_inc("a_sel2", 2);
      do_hold("a_p2", 10'd168, 1, 5'b00111, 0);
      press_inc("a_sel3", 3);
      do_hold("a_p3", 10'd152, 1, 5'b01111, 0);
      press_inc("a_sel4", 4);
      do_hold("a_p4", 10'd136, 3, 5'b11111, 0);
      key = 8'h00;
      expect_v("a_unl_st", F_ST, 3);
      expect_v("a_unl", F_UNL, 1);
      expect_v("a_unl_nf", F_FAIL, 0);
      expect_v("a_unl_dir", F_DIR, 0);
      tick();
      start = 1'b1;
      expect_v("a_idle", F_ST, 0);
      expect_v("a_idle_unl", F_UNL, 0);
      tick();
      start = 1'b0;

      // Wrong pin three times -> FAILED (pickY 202 is inside pin 0 window)
      do_reset("rst1");
      do_start("b_start", pack(2, 0, 1, 3, 4), 10'd202);
      do_hold("b_miss1", 10'd202, 1, 0, 1);
      do_hold("b_miss2", 10'd202, 1, 0, 2);
      do_hold("b_miss3", 10'd202, 4, 0, 3);
      key = 8'h1A;
      expect_v("b_fail", F_FAIL, 1);
      expect_v("b_fail_nu", F_UNL, 0);
      expect_v("b_fail_dir", F_DIR, 0);
      expect_v("b_fail_st", F_ST, 4);
      tick();
      start = 1'b1;
      expect_v("b_idle", F_ST, 0);
      expect_v("b_idle_f", F_FAIL, 0);
      tick();
      start = 1'b0;

      // Pin select edge detection and saturation; start ignored in PICKING
      do_reset("rst2");
      do_start("c_start", pack(0, 1, 2, 3, 4), 10'd0);
      key = 8'h07; start = 1'b1;
      repeat (10) begin expect_v("c_held", F_PIN, 1); expect_v("c_nostart", F_ST, 1); tick(); end
      start = 1'b0;
      key = 8'h00; expect_v("c_rel", F_PIN, 1); tick();
      press_inc("c_press2", 2);
      for (int i = 0; i < 5; i++) begin
         key = 8'h00; tick();
         press_inc("c_sat", (i < 2) ? 3 + i : 4);
      end

      // Motion decode, one frame of latency
      for (int i = 0; i < 5; i++) begin
         key = kc_tab[i];
         expect_v("d_dir", F_DIR, dir_tab[i]);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         key = 8'h00; tick();
         key = 8'h04;
         expect_v("d_dec", F_PIN, (i < 4) ? 3 - i : 0);
         tick();
      end

      // Hold broken at frame 29, window boundaries, reset mid-hold and in CHECK
      do_reset("rst3");
      do_start("e_start", pack(0, 1, 2, 3, 4), 10'd200);
      repeat (29) begin expect_v("e_hold29", F_ST, 1); tick(); end
      py = 10'd205;
      expect_v("e_break", F_ST, 1);
      tick();
      do_hold("e_low", 10'd196, 1, 5'b00001, 0);
      press_inc("e_sel1", 1);
      py = 10'd188;
      repeat (10) begin expect_v("e_mid", F_ST, 1); tick(); end
      do_reset("e_rst_mid");
      do_start("e_start2", pack(0, 1, 2, 3, 4), 10'd200);
      repeat (29) begin expect_v("e_rehold", F_ST, 1); tick(); end
      expect_v("e_chk", F_ST, 2);
      tick();
      do_reset("e_rst_chk");

      // Drain the scoreboard within a bounded number of frames
      for (int i = 0; i < 5 && sq.size() > 0; i++) tick();
      if (sq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pin_sequencer.md
PIN_SEQUENCER -- requirements
Module: pin_sequencer

Interface
REQ-001 Parameter NUM_PINS, 5, number of lock pins (pin indices 0..4).
REQ-002 Parameter PIN_Y_BASE, 10'd200, target Y of pin 0; target(i) = PIN_Y_BASE - PIN_Y_STEP*i.
REQ-003 Parameter PIN_Y_STEP, 10'd16, target Y spacing between adjacent pins.
REQ-004 Parameter WINDOW, 10'd4, hit when |pickY - target(active_pin)| <= WINDOW.
REQ-005 Parameter HOLD_FRAMES, 8'd30, consecutive in-window frames required to attempt a set.
REQ-006 Parameter MAX_STRIKES, 2'd3, wrong-order attempts before failure.
REQ-007 Ports: frame_clk in 1, the only clock; Reset in 1, synchronous, active-high.
REQ-008 Ports: start in 1, begin or acknowledge a round; keycode in 8, current key (0x00 = none); bind_order in 15, five 3-bit pin indices, slot k at bits [3k+2:3k]; pickY in 10, pick Y position.
REQ-009 Ports: dir out 3, motion code to the pick (000 stop, 001 up 1, 010 down 1, 011 down 2, 100 up 2); active_pin out 3; pin_set out 5, one bit per set pin; strikes out 2; state out 3; unlocked out 1; failed out 1.

Function
REQ-010 FSM states SHALL be IDLE=0, PICKING=1, CHECK=2, UNLOCKED=3, FAILED=4, output on state.
REQ-011 IDLE: dir=000; start=1 -> PICKING next frame; bind_order latched; pin_set, strikes, next_idx, hold_cnt, active_pin cleared.
REQ-012 PICKING: dir registered from keycode (1-frame latency): 0x1A->001, 0x16->010, 0x52->100, 0x51->011, any other->000.
REQ-013 PICKING: keycode 0x04 (0x07) SHALL decrement (increment) active_pin once per press, detected as keycode change vs. previous frame; saturate at 0 and NUM_PINS-1.
REQ-014 Any active_pin change SHALL clear hold_cnt in the same frame.
REQ-015 PICKING: hold_cnt increments each frame when in window and pin_set[active_pin]=0; otherwise clears to 0.
REQ-016 Window compare SHALL use unsigned 10-bit absolute difference, no wrap.
REQ-017 hold_cnt reaching HOLD_FRAMES -> CHECK; hold_cnt cleared; dir forced 000 in CHECK.
REQ-018 CHECK (one frame): active_pin == bind_order slot next_idx -> set pin_set[active_pin], next_idx+1; else pin_set cleared, next_idx=0, strikes+1.
REQ-019 CHECK exit: next_idx reaches NUM_PINS -> UNLOCKED; strikes reaches MAX_STRIKES -> FAILED; else PICKING.
REQ-020 UNLOCKED: unlocked=1, dir=000; FAILED: failed=1, dir=000; both hold until start=1, then IDLE.
REQ-021 start SHALL be ignored in PICKING and CHECK.
REQ-022 unlocked and failed SHALL never be 1 together; both 0 outside their states.
REQ-023 Duplicate indices or values >= NUM_PINS in bind_order SHALL make that slot unsatisfiable; no other special handling.

Reset
REQ-024 Reset=1 at a frame_clk edge SHALL force state=IDLE, dir=000, active_pin=0, pin_set=0, strikes=0, unlocked=0, failed=0, hold_cnt=0, next_idx=0, keycode history=0, from any state including mid-hold and CHECK.

Verification
REQ-025 Reset, start with bind_order={4,3,2,1,0} packed 0, pickY=200, active_pin=0 -> after 30 in-window frames state=CHECK, next frame pin_set=00001, state=PICKING.
REQ-026 bind_order slot0=2, active_pin=0, 30 frames at pickY=202 -> CHECK, strikes=1, pin_set=00000; third such miss -> FAILED, failed=1, dir=000.
REQ-027 keycode 0x07 held 10 frames -> active_pin=1 only; 0x00 then 0x07 -> 2; five further presses -> saturates at 4.
REQ-028 Correct order, pickY set to target(i) per pin -> after fifth CHECK state=UNLOCKED, pin_set=11111; start -> IDLE.
REQ-029 Hold at frame 29 then pickY=205 (window 4, target 200) -> hold_cnt=0, no CHECK; Reset asserted mid-hold -> all outputs at reset values next edge.
REQ-030 PICKING keycodes 0x1A, 0x16, 0x52, 0x51, 0x2C -> dir 001, 010, 100, 011, 000 one frame later.
